// File: rtl/adc_sample_buffer.sv
// Word FIFO between the ADC serial front end and the host MCU.
// Each stored word is unloaded as four bytes, MSB first, paced by an asynchronous host strobe.
module adc_sample_buffer #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [31:0]           write_data,
    output logic                  buffer_full,
    input  logic                  host_read_strobe,
    output logic [7:0]            host_data,
    output logic                  host_data_valid,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [31:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [ADDR_WIDTH:0]     count_next;
    logic                    full_reg;
    logic                    overflow_reg;
    logic [31:0]             shift_reg;
    logic [1:0]              byte_index_reg;
    logic [7:0]              host_data_reg;
    logic                    valid_reg;
    logic                    sync1_reg;
    logic                    sync2_reg;
    logic                    sync3_reg;

    logic                    strobe_edge;
    logic                    push;
    logic                    pop;
    logic                    advance;
    logic                    finish;
    logic [31:0]             rd_word;

    // Full is judged on the registered flag, so a pop in the same cycle never frees room for a push.
    assign push        = write_enable && !full_reg;
    assign strobe_edge = sync2_reg && !sync3_reg;
    assign rd_word     = mem[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (strobe_edge) begin
                    if (byte_index_reg == 2'd3) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The synchronizer keeps its history across clear so a strobe already high is not a new edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= host_read_strobe;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            shift_reg      <= '0;
            byte_index_reg <= 2'd0;
            host_data_reg  <= 8'h00;
            valid_reg      <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            shift_reg      <= '0;
            byte_index_reg <= 2'd0;
            host_data_reg  <= 8'h00;
            valid_reg      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (write_enable && full_reg) begin
                overflow_reg <= 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_COUNT);

            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                shift_reg      <= {rd_word[23:0], 8'h00};
                host_data_reg  <= rd_word[31:24];
                valid_reg      <= 1'b1;
                byte_index_reg <= 2'd0;
            end else if (advance) begin
                // shift_reg always holds the not-yet-presented bytes left-aligned
                host_data_reg  <= shift_reg[31:24];
                shift_reg      <= {shift_reg[23:0], 8'h00};
                byte_index_reg <= byte_index_reg + 2'd1;
            end else if (finish) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign buffer_full     = full_reg;
    assign word_count      = count_reg;
    assign overflow        = overflow_reg;
    assign host_data       = host_data_reg;
    assign host_data_valid = valid_reg;

endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
- Word FIFO directly downstream of the ADC serial front end.
- Write side accepts 32-bit channel words on a single-cycle write strobe and returns a full flag, which the front end uses to suppress writes.
- Read side presents each word to the host MCU as four bytes, MSB first, on an 8-bit port. The MCU paces the bytes with an asynchronous read strobe.
- Tracks occupancy and latches a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4, log2 of FIFO depth (DEPTH = 2^ADDR_WIDTH = 16 words).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush; priority over all other activity
- write_enable  input  1  one-cycle write strobe from ADC front end
- write_data  input  32  channel word to store
- buffer_full  output  1  registered, high when count == DEPTH
- host_read_strobe  input  1  MCU byte-advance strobe, asynchronous to clock
- host_data  output  8  current byte presented to MCU
- host_data_valid  output  1  high while host_data holds an unread byte
- word_count  output  ADDR_WIDTH+1  words stored, excluding the word being unloaded
- overflow  output  1  sticky; set by a write attempted while full

Behaviour:
- Reset (async) sets all of the following: pointers=0, word_count=0, buffer_full=0, overflow=0, host_data=8'h00, host_data_valid=0, state=IDLE, byte_index=0, strobe sync flops=0.
- Reset mid-unload abandons the partial word; no resume.
- clear (sync) has the same effect as reset, except the strobe synchronizer keeps its history so a strobe already high is not seen as a new edge.
- Write: if write_enable && !buffer_full, store mem[wr_ptr]<=write_data, wr_ptr++ (wraps modulo DEPTH), count++.
- Write while full: data dropped, pointers unchanged, overflow<=1 (held until reset/clear).
- buffer_full and word_count are registered and reflect the state after the current edge.
- Strobe synchronizer: 2 flops plus a third flop for edge history. strobe_edge = sync2 && !sync3.
  - An MCU rising edge therefore takes effect 3 clocks after it appears.
  - A strobe held high counts once; pulses narrower than 1 clock period are not guaranteed to be detected.
- Unload FSM states:
  - IDLE: host_data_valid=0. If count!=0:
    - shift_reg<=mem[rd_ptr]; rd_ptr++ (wraps); count--.
    - host_data<=mem[rd_ptr][31:24]; host_data_valid<=1; byte_index<=0.
    - Next state SHIFT.
    - Latency: first byte is valid 1 clock after a word enters an empty FIFO.
  - SHIFT, on strobe_edge:
    - byte_index<3: byte_index++; host_data<=next byte in order [23:16], [15:8], [7:0].
    - byte_index==3: host_data_valid<=0; next state IDLE.
    - The next word pops on the following cycle if available, so valid drops for exactly 1 clock between words.
  - SHIFT, no edge: hold host_data and byte_index.
  - strobe_edge in IDLE is ignored.
- Simultaneous push and pop in the same cycle: count unchanged; buffer_full unchanged. Write and read addresses may coincide only when count==0, where no pop occurs, so there is no read-during-write hazard.
- Push into a full FIFO in the same cycle as a pop from IDLE: the write is still rejected (full is evaluated on the registered flag). overflow is set.
- word_count width holds 0..DEPTH inclusive.

Test Plan:
- Single word: reset, write 32'hA1B2C3D4. Expect valid=1 next clock with host_data=A1. Three strobe edges give B2, C3, D4. Fourth edge drops valid; word_count returns to 0.
- Fill and overflow: 16 writes with no strobes.
  - After the first write the word is popped, so word_count=15 and buffer_full=0.
  - Write 17 gives count=16, buffer_full=1.
  - Write 18 (data 32'hDEADBEEF) sets overflow=1, count stays 16, and the word never appears at host_data.
- Wrap-around: write and unload 40 words with incrementing data 0..39 interleaved. Verify byte order and data sequence are exact across pointer wrap; overflow stays 0.
- Simultaneous: with count=5 and FSM in IDLE, assert write_enable in the pop cycle. word_count stays 5 and the new word lands last in order.
- Strobe handling: hold strobe high 20 clocks, expect exactly one byte advance. Strobe asserted in IDLE with empty FIFO causes no state change.
- Flush/reset mid-word:
  - Clear asserted after byte 1 gives count=0, valid=0, overflow=0 next clock; a subsequent write unloads cleanly from A1.
  - Async reset with clock stopped clears all outputs immediately.
